// File: rtl/mux_2x1_bh.sv
// mux_2x1_bh: behavioural 2-to-1 multiplexer with a combinational output and a
// registered, reset-defined copy plus a "captured" flag.
// Optional feature macro: MUX2X1_BH_PARITY_EN adds a registered parity output
// y_par (XOR-reduction of the captured value, or of RESET_VAL on reset).
module mux_2x1_bh #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             s,
  input  logic             en,
  output logic [WIDTH-1:0] y_comb,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
`ifdef MUX2X1_BH_PARITY_EN
  ,
  output logic             y_par
`endif
);

  // Zero-latency select, independent of rst and en
  always_comb begin
    y_comb = s ? i1 : i0;
  end

  // Registered select: reset dominates enable; hold when en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= RESET_VAL;
      y_valid <= 1'b0;
    end else if (en) begin
      y       <= y_comb;
      y_valid <= 1'b1;
    end
  end

`ifdef MUX2X1_BH_PARITY_EN
  // Parity tracks y exactly, so it follows the same reset/enable priority
  always_ff @(posedge clk) begin
    if (rst) begin
      y_par <= ^RESET_VAL;
    end else if (en) begin
      y_par <= ^y_comb;
    end
  end
`endif

endmodule

// File: tb/tb_mux_2x1_bh.sv
// tb_mux_2x1_bh: directed plus short random stimulus against two instances
// (WIDTH=1 and WIDTH=8). Expected registered results are queued when inputs
// are driven and popped after the capturing edge.
module tb_mux_2x1_bh;

  localparam logic [7:0] RV8 = 8'h5A;

  typedef struct {
    logic       y1;
    logic       v1;
    logic [7:0] y8;
    logic       v8;
    logic       p8;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst1, s1, en1, i0_1, i1_1;
  logic       rst8, s8, en8;
  logic [7:0] i0_8, i1_8;
  logic       yc1, y1, v1;
  logic [7:0] yc8, y8;
  logic       v8;
`ifdef MUX2X1_BH_PARITY_EN
  logic       p1, p8;
`endif

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  exp_t        sb[$];

  // model state
  logic       m1_y, m1_v, m8_y_p;
  logic [7:0] m8_y;
  logic       m8_v;

  always #5 clk = ~clk;

  mux_2x1_bh #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
    .clk(clk), .rst(rst1), .i0(i0_1), .i1(i1_1), .s(s1), .en(en1),
    .y_comb(yc1), .y(y1), .y_valid(v1)
`ifdef MUX2X1_BH_PARITY_EN
    , .y_par(p1)
`endif
  );

  mux_2x1_bh #(.WIDTH(8), .RESET_VAL(RV8)) u_dut8 (
    .clk(clk), .rst(rst8), .i0(i0_8), .i1(i1_8), .s(s8), .en(en8),
    .y_comb(yc8), .y(y8), .y_valid(v8)
`ifdef MUX2X1_BH_PARITY_EN
    , .y_par(p8)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // combinational check, a moment after inputs settle
  task automatic chk_comb(input string tag);
    logic [7:0] e8;
    logic       e1;
    #1;
    e1 = s1 ? i1_1 : i0_1;
    e8 = s8 ? i1_8 : i0_8;
    chk({tag, "_yc1"}, {7'b0, yc1}, {7'b0, e1});
    chk({tag, "_yc8"}, yc8, e8);
  endtask

  // push expected post-edge state, clock once, pop and compare
  task automatic cycle(input string tag);
    exp_t e, g;
    e.y1 = m1_y;  e.v1 = m1_v;
    e.y8 = m8_y;  e.v8 = m8_v;  e.p8 = m8_y_p;
    if (rst1) begin
      e.y1 = 1'b0; e.v1 = 1'b0;
    end else if (en1) begin
      e.y1 = s1 ? i1_1 : i0_1; e.v1 = 1'b1;
    end
    if (rst8) begin
      e.y8 = RV8; e.v8 = 1'b0; e.p8 = ^RV8;
    end else if (en8) begin
      e.y8 = s8 ? i1_8 : i0_8; e.v8 = 1'b1; e.p8 = ^(s8 ? i1_8 : i0_8);
    end
    m1_y = e.y1; m1_v = e.v1; m8_y = e.y8; m8_v = e.v8; m8_y_p = e.p8;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty expected entry", tag);
    end
    if (sb.size() != 0) begin
      g = sb.pop_front();
      chk({tag, "_y1"}, {7'b0, y1}, {7'b0, g.y1});
      chk({tag, "_v1"}, {7'b0, v1}, {7'b0, g.v1});
      chk({tag, "_y8"}, y8, g.y8);
      chk({tag, "_v8"}, {7'b0, v8}, {7'b0, g.v8});
`ifdef MUX2X1_BH_PARITY_EN
      chk({tag, "_p8"}, {7'b0, p8}, {7'b0, g.p8});
      chk({tag, "_p1"}, {7'b0, p1}, {7'b0, g.y1});
`endif
    end
  endtask

  initial begin
    m1_y = 1'b0; m1_v = 1'b0; m8_y = '0; m8_v = 1'b0; m8_y_p = 1'b0;
    rst1 = 1'b1; i0_1 = 1'b0; i1_1 = 1'b0; s1 = 1'b0; en1 = 1'b1;
    rst8 = 1'b1; i0_8 = 8'h00; i1_8 = 8'h00; s8 = 1'b0; en8 = 1'b1;
    @(negedge clk);

    // reset with en=1
    chk_comb("rst");
    cycle("rst");

    // select i0 (1-bit); capture A5 via i1 (8-bit)
    rst1 = 1'b0; i0_1 = 1'b1; i1_1 = 1'b0; s1 = 1'b0; en1 = 1'b1;
    rst8 = 1'b0; i0_8 = 8'h11; i1_8 = 8'hA5; s8 = 1'b1; en8 = 1'b1;
    chk_comb("sel_i0");
    cycle("sel_i0");

    // i0 low / i1 high / s=0; 8-bit hold with en=0 while y_comb moves
    i0_1 = 1'b0; i1_1 = 1'b1; s1 = 1'b0;
    en8 = 1'b0; i0_8 = 8'h3C; s8 = 1'b0;
    chk_comb("i0_lo");
    cycle("i0_lo");

    // select i1 = 0; 8-bit reset with en=1 (reset priority)
    i0_1 = 1'b1; i1_1 = 1'b0; s1 = 1'b1;
    rst8 = 1'b1; en8 = 1'b1;
    chk_comb("sel_i1a");
    cycle("sel_i1a");

    // select i1 = 1; 8-bit held after reset, y_valid stays low
    i0_1 = 1'b0; i1_1 = 1'b1; s1 = 1'b1;
    rst8 = 1'b0; en8 = 1'b0; i0_8 = 8'hFF;
    chk_comb("sel_i1b");
    cycle("sel_i1b");

    // select i1 = 0; 8-bit parity case i1=07
    i0_1 = 1'b0; i1_1 = 1'b0; s1 = 1'b1;
    en8 = 1'b1; i1_8 = 8'h07; s8 = 1'b1;
    chk_comb("sel_i1c");
    cycle("sel_i1c");

    // 1-bit hold with en=0; 8-bit parity case i0=03
    en1 = 1'b0; i0_1 = 1'b1; s1 = 1'b0;
    i0_8 = 8'h03; s8 = 1'b0;
    chk_comb("hold1");
    cycle("hold1");

    // 1-bit mid-operation reset with en=0
    rst1 = 1'b1;
    chk_comb("rst1_mid");
    cycle("rst1_mid");
    rst1 = 1'b0;

    // short random run
    for (int k = 0; k < 40; k++) begin
      rst1 = ($urandom_range(0, 7) == 0);
      rst8 = ($urandom_range(0, 7) == 0);
      en1  = $urandom_range(0, 1) == 1;
      en8  = $urandom_range(0, 1) == 1;
      s1   = $urandom_range(0, 1) == 1;
      s8   = $urandom_range(0, 1) == 1;
      i0_1 = $urandom_range(0, 1) == 1;
      i1_1 = $urandom_range(0, 1) == 1;
      i0_8 = 8'($urandom_range(0, 255));
      i1_8 = 8'($urandom_range(0, 255));
      chk_comb("rnd");
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
